// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS CPU memory-bus initiator.
package mips_bus_pkg;

  // Transfer size as carried on req_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Bus-cycle sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2
  } state_e;

  // Byte-lane enables for aligned word and half-word transfers.
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // Request fields still needed after the command phase (load extraction).
  typedef struct packed {
    size_e      size;
    logic [1:0] addr_lo;
    logic       sgn;
  } lane_ctl_t;

endpackage

// File: rtl/mips_bus_lane_align.sv
// Byte-lane steering: byteenable/writedata generation for stores,
// lane extraction plus sign/zero extension for loads, alignment check.
// Purely combinational.
module mips_bus_lane_align
  import mips_bus_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte and half-word out of the returned word.
  always_comb begin
    lane_b = rdata[7:0];
    case (addr_lo)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Size-dependent lane enables, store replication, load extension.
  // The misalign flag also covers the reserved size: either way no bus cycle.
  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    misalign   = 1'b0;
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{sgn & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{sgn & lane_h[15]}}, lane_h};
        misalign   = addr_lo[0];
      end
      SZ_WORD: begin
        be       = BE_WORD;
        misalign = |addr_lo;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_bus_initiator.sv
// CPU-side memory-bus initiator: one load/store at a time, word-aligned bus
// cycle with byte enables, honours waitrequest, returns extended load data.
// Optional build macro BUS_TIMEOUT_EN aborts a cycle stalled for
// TIMEOUT_CYCLES clocks with an error response.
module mips_bus_initiator
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  state_e      state, state_nxt;
  lane_ctl_t   ctl_q, ctl_mux;
  logic        read_nxt, write_nxt;
  logic        rsp_valid_nxt, rsp_err_nxt;
  logic [31:0] rsp_rdata_nxt;
  logic        start, abort;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rext;
  logic        al_mis;

  assign req_ready = (state == IDLE);

  // While idle the aligner checks/steers the incoming request; afterwards it
  // extracts load data using the latched size/offset/sign.
  assign ctl_mux = (state == IDLE)
                 ? '{size: size_e'(req_size), addr_lo: req_addr[1:0], sgn: req_signed}
                 : ctl_q;

  mips_bus_lane_align u_align (
    .size       (ctl_mux.size),
    .addr_lo    (ctl_mux.addr_lo),
    .sgn        (ctl_mux.sgn),
    .wdata      (req_wdata),
    .rdata      (readdata),
    .be         (al_be),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rext),
    .misalign   (al_mis)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);
  logic [CW-1:0] tmo_cnt;

  // Stall counter: cleared when a command starts, counts waitrequest cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          tmo_cnt <= '0;
    else if (start)                      tmo_cnt <= '0;
    else if (state == CMD && waitrequest) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Abort on the edge where the count would reach the limit.
  assign abort = (state == CMD) && waitrequest && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  // Next state, next bus strobes and the response to issue next cycle.
  always_comb begin
    state_nxt     = state;
    read_nxt      = read;
    write_nxt     = write;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_rdata_nxt = '0;
    start         = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (al_mis) begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
          end else begin
            start     = 1'b1;
            state_nxt = CMD;
            read_nxt  = !req_write;
            write_nxt = req_write;
          end
        end
      end
      CMD: begin
        if (abort) begin
          state_nxt     = IDLE;
          read_nxt      = 1'b0;
          write_nxt     = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
        end else if (!waitrequest) begin
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          if (write) begin
            state_nxt     = IDLE;
            rsp_valid_nxt = 1'b1;
          end else begin
            state_nxt = RDATA;
          end
        end
      end
      RDATA: begin
        state_nxt     = IDLE;
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = al_rext;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bus outputs and latched request; address/lanes/data frozen for the cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      ctl_q      <= '{size: SZ_BYTE, addr_lo: 2'b00, sgn: 1'b0};
    end else begin
      read  <= read_nxt;
      write <= write_nxt;
      if (start) begin
        address    <= {req_addr[31:2], 2'b00};
        byteenable <= al_be;
        writedata  <= req_write ? al_wdata : '0;
        ctl_q      <= ctl_mux;
      end
    end
  end

  // Single-cycle response pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mips_bus_initiator.sv
// Bench for mips_bus_initiator: memory responder with programmable stalls,
// a byte-level reference model and a per-cycle compare process.
// With BUS_TIMEOUT_EN defined an extra stuck-waitrequest case runs.
module tb_mips_bus_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] address, writedata, readdata;
  logic        write, read, waitrequest;
  logic [3:0]  byteenable;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_bus_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .address(address), .write(write), .read(read),
    .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- responder ----------------
  logic [31:0] mem [16];
  int          stall_req;
  int          stall_used;

  assign waitrequest = (read || write) && (stall_used < stall_req);

  always @(posedge clk or negedge reset) begin
    if (!reset)               stall_used <= 0;
    else if (!(read || write)) stall_used <= 0;
    else if (waitrequest)     stall_used <= stall_used + 1;
  end

  always @(posedge clk) begin
    if (write && !waitrequest)
      for (int k = 0; k < 4; k++)
        if (byteenable[k]) mem[address[5:2]][8*k +: 8] = writedata[8*k +: 8];
    readdata <= (read && !waitrequest) ? mem[address[5:2]] : 32'hDEADBEEF;
  end

  // ---------------- reference model ----------------
  logic [31:0] mm [16];
  logic        exp_err, exp_bus, exp_wr, pending;
  logic [31:0] exp_addr, exp_wd, exp_rdata;
  logic [3:0]  exp_be;
  int          strobe_cnt;

  task automatic model_expect(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd, input bit tmo);
    int n, off;
    logic [31:0] mask, val;
    logic bad;
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off  = int'(a % 4);
    bad  = (sz == 2'b11) || ((a % n) != 0);
    exp_err  = bad || tmo;
    exp_bus  = !bad;
    exp_wr   = wr;
    exp_addr = a - off;
    exp_be   = 4'(((1 << n) - 1) << off);
    for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = wd[8*(k % n) +: 8];
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
    val  = (mm[a[5:2]] >> (8*off)) & mask;
    if (sg && val[8*n-1]) val = val | ~mask;
    exp_rdata = (wr || exp_err) ? 32'd0 : val;
    if (wr && !exp_err)
      for (int k = 0; k < 4; k++)
        if (exp_be[k]) mm[a[5:2]][8*k +: 8] = exp_wd[8*k +: 8];
    pending = 1'b1;
  endtask

  // Per-cycle compare: bus fields while a strobe is up, response when valid.
  always @(negedge clk) begin
    if (reset) begin
      if (read || write) begin
        strobe_cnt++;
        check("bus_read", read, exp_bus && !exp_wr);
        check("bus_write", write, exp_bus && exp_wr);
        check("bus_address", address, exp_addr);
        check("bus_byteenable", byteenable, exp_be);
        if (write) check("bus_writedata", writedata, exp_wd);
      end
      if (rsp_valid) begin
        if (!pending) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
        end else begin
          check("rsp_err", rsp_err, exp_err);
          check("rsp_rdata", rsp_rdata, exp_rdata);
        end
        pending = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input int stall,
                     input bit tmo, output logic [31:0] rd, output logic er,
                     output int lat, output int strobes);
    @(negedge clk);
    check("ready_idle", req_ready, 1);
    stall_req  = stall;
    strobe_cnt = 0;
    model_expect(wr, sz, sg, a, wd, tmo);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; rd = 'x; er = 1'bx;
    forever begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        rd = rsp_rdata; er = rsp_err;
        check("ready_on_rsp", req_ready, 1);
        break;
      end
      if (lat > 2000) begin
        checks++; errors++;
        $display("FAIL rsp_timeout: got no rsp_valid expected one within 2000 cycles");
        break;
      end
    end
    strobes = strobe_cnt;
  endtask

  task automatic run(input string name, input logic wr, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] wd,
                     input int stall, input bit tmo, input logic [31:0] x_rd,
                     input logic x_err, input int x_lat, input int x_str);
    logic [31:0] rd; logic er; int lat, str;
    txn(wr, sz, sg, a, wd, stall, tmo, rd, er, lat, str);
    check({name, "_rdata"}, rd, x_rd);
    check({name, "_err"}, er, x_err);
    check({name, "_latency"}, lat, x_lat);
    check({name, "_strobes"}, str, x_str);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    stall_req = 0; pending = 1'b0; strobe_cnt = 0;
    exp_err = 0; exp_bus = 0; exp_wr = 0; exp_addr = 0; exp_wd = 0; exp_rdata = 0; exp_be = 0;
    for (int i = 0; i < 16; i++) begin mem[i] = 32'd0; mm[i] = 32'd0; end
    mem[11] = 32'hAA1122CC; mm[11] = 32'hAA1122CC;
    mem[12] = 32'h11223344; mm[12] = 32'h11223344;

    repeat (2) @(negedge clk);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_address", address, 0);
    check("rst_writedata", writedata, 0);
    check("rst_byteenable", byteenable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req_ready", req_ready, 1);
    reset = 1'b1;

    //  name        wr sz    sg addr          wdata         st tmo rdata          err lat str
    run("lhu",      0, 2'b01, 0, 32'hBFC0002E, 32'h0,        0, 0, 32'h0000AA11, 0, 3, 1);
    run("lh",       0, 2'b01, 1, 32'hBFC0002E, 32'h0,        0, 0, 32'hFFFFAA11, 0, 3, 1);
    run("lb",       0, 2'b00, 1, 32'hBFC0002C, 32'h0,        0, 0, 32'hFFFFFFCC, 0, 3, 1);
    run("lbu",      0, 2'b00, 0, 32'hBFC0002D, 32'h0,        0, 0, 32'h00000022, 0, 3, 1);
    run("lw",       0, 2'b10, 0, 32'hBFC0002C, 32'h0,        0, 0, 32'hAA1122CC, 0, 3, 1);
    run("sb_wait",  1, 2'b00, 0, 32'hBFC00031, 32'h0000005A, 3, 0, 32'h00000000, 0, 5, 4);
    run("lw_sb",    0, 2'b10, 0, 32'hBFC00030, 32'h0,        0, 0, 32'h11225A44, 0, 3, 1);
    run("sh_hi",    1, 2'b01, 0, 32'hBFC00032, 32'h0000BEEF, 1, 0, 32'h00000000, 0, 3, 2);
    run("lhu_wait", 0, 2'b01, 0, 32'hBFC00032, 32'h0,        2, 0, 32'h0000BEEF, 0, 5, 3);
    run("lw_sh",    0, 2'b10, 0, 32'hBFC00030, 32'h0,        0, 0, 32'hBEEF5A44, 0, 3, 1);
    run("sw",       1, 2'b10, 0, 32'hBFC00000, 32'h80000001, 0, 0, 32'h00000000, 0, 2, 1);
    run("lb_neg",   0, 2'b00, 1, 32'hBFC00003, 32'h0,        0, 0, 32'hFFFFFF80, 0, 3, 1);
    run("lbu_lo",   0, 2'b00, 0, 32'hBFC00000, 32'h0,        0, 0, 32'h00000001, 0, 3, 1);
    run("lh_neg",   0, 2'b01, 1, 32'hBFC00002, 32'h0,        0, 0, 32'hFFFF8000, 0, 3, 1);
    run("lw_mis",   0, 2'b10, 0, 32'hBFC00002, 32'h0,        0, 0, 32'h00000000, 1, 1, 0);
    run("lh_mis",   0, 2'b01, 1, 32'hBFC00001, 32'h0,        0, 0, 32'h00000000, 1, 1, 0);
    run("rsvd",     0, 2'b11, 0, 32'hBFC00000, 32'h0,        0, 0, 32'h00000000, 1, 1, 0);
    run("sw_mis",   1, 2'b10, 0, 32'hBFC00001, 32'h12345678, 0, 0, 32'h00000000, 1, 1, 0);

    // Reset in the middle of a stalled read: drop strobes, no response.
    @(negedge clk);
    stall_req = 1000;
    model_expect(0, 2'b10, 0, 32'hBFC0002C, 32'h0, 0);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'hBFC0002C;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst_read_before", read, 1);
    @(negedge clk); #2;
    reset = 1'b0;
    pending = 1'b0;
    #1;
    check("midrst_read_async", read, 0);
    check("midrst_write_async", write, 0);
    @(negedge clk);
    check("midrst_no_rsp", rsp_valid, 0);
    stall_req = 0;
    reset = 1'b1;
    #1;
    check("midrst_ready", req_ready, 1);
    run("lw_after_rst", 0, 2'b10, 0, 32'hBFC0002C, 32'h0, 0, 0, 32'hAA1122CC, 0, 3, 1);

`ifdef BUS_TIMEOUT_EN
    run("timeout",  0, 2'b10, 0, 32'hBFC0002C, 32'h0, 1000, 1, 32'h00000000, 1, 9, 8);
    run("lw_after_tmo", 0, 2'b10, 0, 32'hBFC0002C, 32'h0, 0, 0, 32'hAA1122CC, 0, 3, 1);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_initiator.md
Name: mips_bus_initiator

Overview:
Initiator (master) side of the CPU memory bus (address/read/write/waitrequest/writedata/byteenable/readdata) that memory responders serve. Accepts one load/store request at a time from the CPU datapath. Drives a word-aligned bus cycle with byte-lane enables and honours waitrequest. Returns zero- or sign-extended load data, or a write-complete response. Sits between the mips_cpu_bus datapath and the external memory.

Parameters:
TIMEOUT_CYCLES, 255, cycles waitrequest may stay high before abort (used only with BUS_TIMEOUT_EN).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready at rising edge
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  in  1  sign-extend load result (lb/lh)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle completion pulse; no backpressure
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned, reserved size, or timeout
address  out  32  bus address, always {req_addr[31:2],2'b00}
write  out  1  bus write strobe
read  out  1  bus read strobe
waitrequest  in  1  responder stall
writedata  out  32  lane-replicated store data
byteenable  out  4  byteenable[k] selects bits 8k+7:8k (little-endian lanes)
readdata  in  32  valid exactly one cycle after the accepting edge of a read

Behaviour:
- Reset (async, active-low): state IDLE; read=0, write=0, address=0, writedata=0, byteenable=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Reset mid-cycle drops read/write immediately. The in-flight request is discarded and gets no response.
- req_ready = (state==IDLE).
- IDLE: on accept, latch the request.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size 11: no bus cycle. Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0. Stay in IDLE.
  - Otherwise go to CMD.
- CMD: assert read or write; address, byteenable and writedata held stable while waitrequest=1.
  - Edge with waitrequest=0 on a write: go to IDLE; rsp_valid=1 next cycle.
  - Edge with waitrequest=0 on a read: go to RDATA.
- RDATA: read=0. Sample readdata at this edge, extract the lane and extend, go to IDLE, and assert rsp_valid with rsp_rdata next cycle.
- Latency with no wait states, request accepted at edge 0:
  - Store: write high during cycle 1; rsp_valid during cycle 2.
  - Load: read high during cycle 1; rsp_valid during cycle 3.
  - Back-to-back requests are accepted in the rsp_valid cycle.
- Byteenable: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
- Writedata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- Load extraction: byte = readdata[8*addr[1:0]+:8]; half = addr[1] ? [31:16] : [15:0]. Extend with the MSB if req_signed, else with zeros.
- Each accepted request produces exactly one rsp_valid pulse.

Optional Feature:
Macro BUS_TIMEOUT_EN.
- Defined: an 8..32-bit counter clears on entering CMD and increments each cycle waitrequest=1. When it reaches TIMEOUT_CYCLES, read/write drop, state goes to IDLE, and next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Undefined: no counter; CMD waits indefinitely.

Decomposition:
- Package mips_bus_pkg: size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD), FSM state enum (IDLE, CMD, RDATA), byteenable constants BE_WORD, BE_HALF_LO, BE_HALF_HI.
- One sub-module, mips_bus_lane_align: purely combinational. Given size, addr[1:0], signed, wdata and readdata, it produces byteenable, writedata, extended load data and the misalign flag. The FSM stays in mips_bus_initiator.

Test Plan:
- Word at 0xBFC0002C = 0xAA1122CC, waitrequest=0. lhu at 0xBFC0002E -> address 0xBFC0002C, byteenable 1100, read high for 1 cycle, rsp_rdata 0x0000AA11 in cycle 3.
- Same word: lh 0xBFC0002E -> 0xFFFFAA11; lb 0xBFC0002C -> 0xFFFFFFCC; lbu 0xBFC0002D -> 0x00000022; lw 0xBFC0002C -> 0xAA1122CC.
- sb 0xBFC00031 with wdata 0x5A, waitrequest high 3 cycles -> write high 4 cycles with address 0xBFC00030, byteenable 0010, writedata 0x5A5A5A5A stable; rsp_valid one cycle after waitrequest drops.
- lw 0xBFC00002 and lh 0xBFC00001 -> read/write never assert; rsp_valid with rsp_err=1 the next cycle; req_size=11 gives the same result.
- Reset low mid-read with waitrequest=1 -> read=0 asynchronously, no rsp_valid; after release req_ready=1 and a new lw completes normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck high -> read drops after 8 stalled cycles; rsp_err=1, rsp_rdata=0.
